sobel_frame_sequencer: RTL and testbench



---
 rtl/sobel_frame_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_sobel_frame_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_sequencer.sv
// rtl/sobel_frame_sequencer.sv - frame sequencer feeding 3x7 windows to the Sobel core and storing its results
module sobel_frame_sequencer #(
    parameter int IMG_W   = 128,
    parameter int IMG_H   = 128,
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 32
) (
    input  logic              clka,
    input  logic              reset,
    input  logic              frame_start,
    input  logic [5:0]        error_in,
    output logic              busy,
    output logic              frame_done,
    output logic              err_timeout,
    output logic [ADDR_W-1:0] img_addr,
    output logic              img_rd_en,
    input  logic [7:0]        img_rd_data,
    output logic              core_start,
    output logic [5:0]        core_error,
    output logic [167:0]      win_pix,
    input  logic              core_done,
    input  logic [39:0]       core_out,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_wr_en,
    output logic [7:0]        out_wr_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAUNCH,
        S_WAIT,
        S_WRITE,
        S_ADVANCE
    } state_t;

    localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] LAST_C = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] LAST_R = ADDR_W'(IMG_H - 3);
    localparam int                TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]     TMO_END = TW'(TIMEOUT - 1);

    state_t            state;
    logic [ADDR_W-1:0] r;
    logic [ADDR_W-1:0] c;
    logic [4:0]        fi;           // window index currently presented on the read port; 21 = drain
    logic [1:0]        fr;
    logic [2:0]        fc;
    logic              rd_pend_en;   // a read issued last cycle returns data this cycle
    logic [4:0]        rd_pend_idx;
    logic [TW-1:0]     tmo;
    logic [2:0]        wk;
    logic [39:0]       result;

    logic [1:0]        fr_n;
    logic [2:0]        fc_n;
    logic [ADDR_W-1:0] col_n;
    logic              col_ok_n;
    logic [ADDR_W-1:0] fetch_addr_n;
    logic [ADDR_W-1:0] rem;
    logic [2:0]        tile_v;
    logic              row_last;
    logic              frame_last;
    logic [ADDR_W-1:0] c_next;
    logic [ADDR_W-1:0] r_next;
    logic [ADDR_W-1:0] tile_addr_n;
    logic [ADDR_W-1:0] wr_base;
    logic [2:0]        wk_n;

    // Next fetch position, tile lane count and next tile origin
    always_comb begin
        fc_n         = (fc == 3'd6) ? 3'd0 : fc + 3'd1;
        fr_n         = (fc == 3'd6) ? fr + 2'd1 : fr;
        col_n        = c + ADDR_W'(fc_n);
        col_ok_n     = col_n < W_A;
        fetch_addr_n = (r + ADDR_W'(fr_n)) * W_A + col_n;
        rem          = LAST_C - c;
        tile_v       = (rem < ADDR_W'(5)) ? rem[2:0] : 3'd5;
        row_last     = (c + ADDR_W'(5)) >= LAST_C;
        c_next       = row_last ? '0 : c + ADDR_W'(5);
        r_next       = row_last ? r + ADDR_W'(1) : r;
        frame_last   = row_last && (r == LAST_R);
        tile_addr_n  = r_next * W_A + c_next;
        wr_base      = (r + ADDR_W'(1)) * W_A + c + ADDR_W'(1);
        wk_n         = wk + 3'd1;
    end

    // Frame sequencing FSM with registered outputs
    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;
            img_addr    <= '0;
            img_rd_en   <= 1'b0;
            core_start  <= 1'b0;
            core_error  <= '0;
            win_pix     <= '0;
            out_addr    <= '0;
            out_wr_en   <= 1'b0;
            out_wr_data <= '0;
            r           <= '0;
            c           <= '0;
            fi          <= '0;
            fr          <= '0;
            fc          <= '0;
            rd_pend_en  <= 1'b0;
            rd_pend_idx <= '0;
            tmo         <= '0;
            wk          <= '0;
            result      <= '0;
        end else begin
            frame_done  <= 1'b0;
            rd_pend_en  <= img_rd_en;
            rd_pend_idx <= fi;
            if (rd_pend_en) begin
                win_pix[8*rd_pend_idx +: 8] <= img_rd_data;
            end
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        core_error  <= error_in;
                        err_timeout <= 1'b0;
                        busy        <= 1'b1;
                        r           <= '0;
                        c           <= '0;
                        fi          <= '0;
                        fr          <= '0;
                        fc          <= '0;
                        img_addr    <= '0;
                        img_rd_en   <= 1'b1;
                        state       <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (fi == 5'd21) begin
                        core_start <= 1'b1;
                        state      <= S_LAUNCH;
                    end else if (fi == 5'd20) begin
                        img_rd_en <= 1'b0;
                        fi        <= 5'd21;
                    end else begin
                        fi        <= fi + 5'd1;
                        fr        <= fr_n;
                        fc        <= fc_n;
                        img_addr  <= fetch_addr_n;
                        img_rd_en <= col_ok_n;
                        if (!col_ok_n) begin
                            win_pix[8*(fi + 5'd1) +: 8] <= 8'h00;
                        end
                    end
                end
                S_LAUNCH: begin
                    core_start <= 1'b0;
                    tmo        <= '0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        result      <= core_out;
                        out_wr_en   <= 1'b1;
                        out_addr    <= wr_base;
                        out_wr_data <= core_out[7:0];
                        wk          <= '0;
                        state       <= S_WRITE;
                    end else if (tmo == TMO_END) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                S_WRITE: begin
                    if (wk_n < tile_v) begin
                        wk          <= wk_n;
                        out_addr    <= out_addr + ADDR_W'(1);
                        out_wr_data <= result[8*wk_n +: 8];
                    end else begin
                        out_wr_en <= 1'b0;
                        state     <= S_ADVANCE;
                    end
                end
                S_ADVANCE: begin
                    if (frame_last) begin
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        r         <= r_next;
                        c         <= c_next;
                        fi        <= '0;
                        fr        <= '0;
                        fc        <= '0;
                        img_addr  <= tile_addr_n;
                        img_rd_en <= 1'b1;
                        state     <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// tb/tb_sobel_frame_sequencer.sv - scoreboard bench for sobel_frame_sequencer
module tb_sobel_frame_sequencer;
    localparam int W  = 14;
    localparam int H  = 4;
    localparam int AW = 14;
    localparam int TO = 32;

    logic          clka = 1'b0;
    logic          reset = 1'b1;
    logic          frame_start = 1'b0;
    logic [5:0]    error_in = '0;
    logic          busy, frame_done, err_timeout;
    logic [AW-1:0] img_addr;
    logic          img_rd_en;
    logic [7:0]    img_rd_data = '0;
    logic          core_start;
    logic [5:0]    core_error;
    logic [167:0]  win_pix;
    logic          core_done = 1'b0;
    logic [39:0]   core_out = '0;
    logic [AW-1:0] out_addr;
    logic          out_wr_en;
    logic [7:0]    out_wr_data;

    sobel_frame_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clka(clka), .reset(reset), .frame_start(frame_start), .error_in(error_in),
        .busy(busy), .frame_done(frame_done), .err_timeout(err_timeout),
        .img_addr(img_addr), .img_rd_en(img_rd_en), .img_rd_data(img_rd_data),
        .core_start(core_start), .core_error(core_error), .win_pix(win_pix),
        .core_done(core_done), .core_out(core_out),
        .out_addr(out_addr), .out_wr_en(out_wr_en), .out_wr_data(out_wr_data)
    );

    always #5 clka = ~clka;

    typedef struct { int r; int c; } tile_t;
    typedef struct { logic [AW-1:0] addr; logic [7:0] data; } wr_t;

    logic [7:0] img_mem [W*H];
    tile_t      tile_q [$];
    wr_t        wr_q [$];
    int         checks = 0;
    int         errors = 0;
    int         rd_cnt = 0;
    int         wr_cnt = 0;
    int         fd_cnt = 0;
    logic [5:0] err_lat = '0;
    bit         core_hang = 0;
    bit         glitch_en = 0;
    int         lat_fixed = 0;

    task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [167:0] exp_window(input int r, input int c);
        logic [167:0] w = '0;
        for (int row = 0; row < 3; row++)
            for (int col = 0; col < 7; col++)
                if (c + col < W) w[8*(7*row+col) +: 8] = img_mem[(r+row)*W + c + col];
        return w;
    endfunction

    // image RAM: synchronous read, data one cycle after the enable
    always @(posedge clka) begin
        if (img_rd_en) begin
            rd_cnt      <= rd_cnt + 1;
            img_rd_data <= (int'(img_addr) < W*H) ? img_mem[img_addr] : 8'h00;
        end
    end

    // output-side monitor
    initial begin
        wr_t e;
        forever begin
            @(negedge clka);
            if (out_wr_en) begin
                wr_cnt++;
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data %0h, none expected", out_addr, out_wr_data);
                end else begin
                    e = wr_q.pop_front();
                    chk("wr_addr", out_addr, e.addr);
                    chk("wr_data", out_wr_data, e.data);
                end
            end
            if (frame_done) begin
                fd_cnt++;
                chk("done_tiles_left", tile_q.size(), 0);
                chk("done_writes_left", wr_q.size(), 0);
                chk("done_busy_low", busy, 0);
            end
            if (busy) chk("core_error_held", core_error, err_lat);
        end
    end

    // behavioural Sobel core
    initial begin
        tile_t        t;
        wr_t          we;
        logic [167:0] ew;
        logic [63:0]  rnd;
        int           lat, v;
        forever begin
            @(negedge clka);
            if (core_start) begin
                if (tile_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_core_start: got 1 expected 0");
                end else begin
                    t  = tile_q.pop_front();
                    ew = exp_window(t.r, t.c);
                    chk("win_pix_at_start", win_pix, ew);
                    chk("core_error_at_start", core_error, err_lat);
                    v = (W - 2 - t.c < 5) ? W - 2 - t.c : 5;
                    if (core_hang) begin
                        repeat (TO) @(negedge clka);
                        chk("timeout_not_early", err_timeout, 0);
                        @(negedge clka);
                        chk("timeout_err", err_timeout, 1);
                        chk("timeout_busy", busy, 0);
                    end else begin
                        lat = (lat_fixed > 0) ? lat_fixed : $urandom_range(1, 10);
                        repeat (lat) @(negedge clka);
                        rnd       = {$urandom(), $urandom()};
                        core_out  = rnd[39:0];
                        core_done = 1'b1;
                        chk("win_pix_held", win_pix, ew);
                        for (int k = 0; k < v; k++) begin
                            we.addr = AW'((t.r + 1) * W + t.c + 1 + k);
                            we.data = rnd[8*k +: 8];
                            wr_q.push_back(we);
                        end
                        @(negedge clka);
                        core_done = 1'b0;
                        chk("first_write_latency", out_wr_en, 1);
                        if (glitch_en) begin
                            repeat (v + 3) @(negedge clka);
                            core_done = 1'b1;
                            core_out  = '1;
                            @(negedge clka);
                            core_done = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic run_frame(input int lat, input bit hang, input bit noise, input int rst_after);
        logic [5:0] e;
        int n, rd0, wr0, fd0, wr1, exp_rd;
        bit cs_seen, done_loop;
        core_hang = hang;
        lat_fixed = lat;
        glitch_en = noise;
        tile_q.delete();
        wr_q.delete();
        exp_rd = 0;
        for (int r = 0; r <= H - 3; r++)
            for (int c = 0; c < W - 2; c += 5) begin
                tile_q.push_back('{r: r, c: c});
                exp_rd += 3 * ((W - c < 7) ? W - c : 7);
            end
        e = 6'($urandom);
        @(negedge clka);
        frame_start = 1'b1;
        error_in    = e;
        err_lat     = e;
        @(negedge clka);
        frame_start = 1'b0;
        error_in    = ~e;
        chk("start_busy", busy, 1);
        chk("start_rd_en", img_rd_en, 1);
        chk("start_img_addr", img_addr, 0);
        chk("start_err_cleared", err_timeout, 0);
        chk("start_core_error", core_error, e);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        fd0 = fd_cnt;
        n = 1;
        cs_seen = 0;
        done_loop = 0;
        while (!done_loop && n < 4000) begin
            @(negedge clka);
            #1;
            n++;
            frame_start = 1'b0;
            if (!cs_seen && core_start) begin
                cs_seen = 1;
                chk("first_launch_latency", n, 23);
            end
            if (rst_after > 0 && wr_cnt - wr0 >= rst_after) begin
                reset = 1'b1;
                #1;
                chk("rst_wr_en", out_wr_en, 0);
                chk("rst_busy", busy, 0);
                chk("rst_rd_en", img_rd_en, 0);
                chk("rst_core_start", core_start, 0);
                chk("rst_img_addr", img_addr, 0);
                chk("rst_out_addr", out_addr, 0);
                chk("rst_out_data", out_wr_data, 0);
                chk("rst_win_pix", win_pix, 0);
                chk("rst_core_error", core_error, 0);
                tile_q.delete();
                wr_q.delete();
                repeat (3) @(negedge clka);
                reset = 1'b0;
                wr1 = wr_cnt;
                repeat (30) @(negedge clka);
                chk("no_write_after_reset", wr_cnt - wr1, 0);
                chk("idle_after_reset", busy, 0);
                done_loop = 1;
            end else if (hang ? !busy : (fd_cnt != fd0)) begin
                done_loop = 1;
            end else if (noise && busy && $urandom_range(0, 5) == 0) begin
                frame_start = 1'b1;
                error_in    = 6'($urandom);
            end
        end
        frame_start = 1'b0;
        chk("frame_completes", done_loop, 1);
        if (rst_after == 0) begin
            chk("frame_done_count", fd_cnt - fd0, hang ? 0 : 1);
            chk("busy_after_frame", busy, 0);
            if (!hang) begin
                chk("read_count", rd_cnt - rd0, exp_rd);
                chk("no_timeout", err_timeout, 0);
            end
            repeat (5) @(negedge clka);
            chk("no_late_done", fd_cnt - fd0, hang ? 0 : 1);
        end
    endtask

    initial begin
        for (int i = 0; i < W*H; i++) img_mem[i] = 8'($urandom);
        reset = 1'b1;
        repeat (3) @(negedge clka);
        chk("reset_busy", busy, 0);
        chk("reset_rd_en", img_rd_en, 0);
        reset = 1'b0;
        @(negedge clka);
        chk("idle_busy", busy, 0);
        chk("idle_frame_done", frame_done, 0);
        chk("idle_err", err_timeout, 0);
        chk("idle_core_start", core_start, 0);
        chk("idle_wr_en", out_wr_en, 0);
        chk("idle_img_addr", img_addr, 0);
        chk("idle_out_addr", out_addr, 0);
        chk("idle_out_data", out_wr_data, 0);
        chk("idle_win_pix", win_pix, 0);
        chk("idle_core_error", core_error, 0);

        run_frame(0, 0, 1, 0);
        run_frame(TO, 0, 0, 0);
        run_frame(0, 1, 0, 0);
        chk("err_sticky", err_timeout, 1);
        repeat (4) @(negedge clka);
        chk("err_still_sticky", err_timeout, 1);
        run_frame(0, 0, 0, 0);
        run_frame(0, 0, 0, 2);
        run_frame(0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
